// File: rtl/sel_ctrl_pkg.sv
// Shared definitions for the selector up/down controller: debounce state
// encodings and the default Selector width and maximum code.
package sel_ctrl_pkg;

   // Debounce FSM states; the two stable levels differ in both bits.
   typedef enum logic [1:0] {
      S_LOW       = 2'b00,
      S_WAIT_HIGH = 2'b01,
      S_HIGH      = 2'b11,
      S_WAIT_LOW  = 2'b10
   } db_state_t;

   localparam int SEL_W_DEF = 3;
   localparam int SEL_MAX   = (1 << SEL_W_DEF) - 1;

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton channel: 2-FF synchronizer, four-state debounce FSM and a
// registered one-cycle press pulse emitted when a high level is qualified.
// Releases are debounced too but never produce a pulse.
module btn_debounce
   import sel_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic press_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [1:0]       sync_q;
   logic             s_btn;
   db_state_t        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             press_q;

   // Two-flop synchronizer for the raw asynchronous button.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], btn_i};
      end
   end

   assign s_btn = sync_q[1];

   // Debounce FSM: a level is accepted only after it stays stable for
   // DEBOUNCE_CYCLES counted cycles; the press pulse marks acceptance of high.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_LOW;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         press_q <= 1'b0;
         case (state_q)
            S_LOW: begin
               if (s_btn) begin
                  state_q <= S_WAIT_HIGH;
                  cnt_q   <= CNT_ONE;
               end
            end
            S_WAIT_HIGH: begin
               if (!s_btn) begin
                  state_q <= S_LOW;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_MAX) begin
                  state_q <= S_HIGH;
                  cnt_q   <= '0;
                  press_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            S_HIGH: begin
               if (!s_btn) begin
                  state_q <= S_WAIT_LOW;
                  cnt_q   <= CNT_ONE;
               end
            end
            S_WAIT_LOW: begin
               if (s_btn) begin
                  state_q <= S_HIGH;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_MAX) begin
                  state_q <= S_LOW;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_q <= S_LOW;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/selector_updown_ctrl.sv
// Debounced up/down pushbutton control of the frequency-select code.
// Each button runs through btn_debounce; the shared counter here steps the
// Selector on a registered press pulse and saturates at 0 and max.
// Build option: define SEL_WRAP_EN to wrap max->0 and 0->max instead.
module selector_updown_ctrl
   import sel_ctrl_pkg::*;
#(
   parameter int               DEBOUNCE_CYCLES = 500000,
   parameter int               SEL_W           = SEL_W_DEF,
   parameter logic [SEL_W-1:0] SEL_RESET       = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_up,
   input  logic             btn_down,
   output logic [SEL_W-1:0] Selector,
   output logic             sel_at_min,
   output logic             sel_at_max,
   output logic             sel_change
);

   localparam logic [SEL_W-1:0] SEL_TOP = '1;
   localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);

   logic             p_up;
   logic             p_dn;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             chg_d, chg_q;
   logic             at_min_q, at_max_q;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (btn_up),
      .press_o(p_up)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (btn_down),
      .press_o(p_dn)
   );

   // Next Selector value; simultaneous presses cancel out.
   always_comb begin
      sel_d = sel_q;
      chg_d = 1'b0;
      if (p_up && !p_dn) begin
`ifdef SEL_WRAP_EN
         sel_d = sel_q + SEL_ONE;
         chg_d = 1'b1;
`else
         if (sel_q != SEL_TOP) begin
            sel_d = sel_q + SEL_ONE;
            chg_d = 1'b1;
         end
`endif
      end else if (p_dn && !p_up) begin
`ifdef SEL_WRAP_EN
         sel_d = sel_q - SEL_ONE;
         chg_d = 1'b1;
`else
         if (sel_q != '0) begin
            sel_d = sel_q - SEL_ONE;
            chg_d = 1'b1;
         end
`endif
      end
   end

   // Selector and its flags register together so they always agree.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q    <= SEL_RESET;
         at_min_q <= (SEL_RESET == '0);
         at_max_q <= (SEL_RESET == SEL_TOP);
         chg_q    <= 1'b0;
      end else begin
         sel_q    <= sel_d;
         at_min_q <= (sel_d == '0);
         at_max_q <= (sel_d == SEL_TOP);
         chg_q    <= chg_d;
      end
   end

   assign Selector   = sel_q;
   assign sel_at_min = at_min_q;
   assign sel_at_max = at_max_q;
   assign sel_change = chg_q;

endmodule

// File: tb/tb_selector_updown_ctrl.sv
// Directed bench for selector_updown_ctrl with DEBOUNCE_CYCLES=4, so a clean
// press steps the Selector 7 edges after the first edge that samples it.
module tb_selector_updown_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_up;
   logic       btn_down;
   logic [2:0] Selector;
   logic       sel_at_min;
   logic       sel_at_max;
   logic       sel_change;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int chg_seen = 0;
   logic [2:0] exp_q[$];

   selector_updown_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .SEL_W          (3),
      .SEL_RESET      (3'd0)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .Selector  (Selector),
      .sel_at_min(sel_at_min),
      .sel_at_max(sel_at_max),
      .sel_change(sel_change)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // advance n edges, sample 1 time unit after each, count sel_change pulses
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (sel_change === 1'b1) chg_seen++;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic press_up();
      btn_up = 1'b1;
      tick(12);
      btn_up = 1'b0;
      tick(12);
   endtask

   task automatic press_dn();
      btn_down = 1'b1;
      tick(12);
      btn_down = 1'b0;
      tick(12);
   endtask

   initial begin
      logic [2:0] e;
      int         exp_chg;
      reset    = 1'b1;
      btn_up   = 1'b0;
      btn_down = 1'b0;

      // reset state
      do_reset();
      check("rst_sel", Selector, 0);
      check("rst_min", sel_at_min, 1);
      check("rst_max", sel_at_max, 0);
      check("rst_chg", sel_change, 0);
      chg_seen = 0;
      tick(20);
      check("idle_sel", Selector, 0);
      check("idle_chg", chg_seen, 0);

      // clean press latency: step exactly on edge N+7
      chg_seen = 0;
      btn_up   = 1'b1;
      tick(7);
      check("lat_early_sel", Selector, 0);
      check("lat_early_chg", chg_seen, 0);
      tick(1);
      check("lat_sel", Selector, 1);
      check("lat_chg", sel_change, 1);
      check("lat_min", sel_at_min, 0);
      tick(1);
      check("lat_chg_off", sel_change, 0);
      chg_seen = 0;
      tick(100);
      check("hold_chg", chg_seen, 0);
      check("hold_sel", Selector, 1);
      btn_up = 1'b0;
      tick(12);

      // bounce then clean hold: one increment 7 edges after the final rise
      chg_seen = 0;
      btn_up = 1'b1; tick(2);
      btn_up = 1'b0; tick(2);
      btn_up = 1'b1; tick(2);
      btn_up = 1'b0; tick(2);
      btn_up = 1'b1;
      tick(7);
      check("bnc_early_sel", Selector, 1);
      check("bnc_early_chg", chg_seen, 0);
      tick(1);
      check("bnc_sel", Selector, 2);
      check("bnc_chg", sel_change, 1);
      btn_up = 1'b0;
      tick(12);
      check("bnc_total", chg_seen, 1);

      // eight presses from 0: saturate (or wrap) on the eighth
      do_reset();
      for (int i = 1; i <= 7; i++) exp_q.push_back(3'(i));
`ifdef SEL_WRAP_EN
      exp_q.push_back(3'd0);
`else
      exp_q.push_back(3'd7);
`endif
      for (int p = 0; p < 8; p++) begin
         chg_seen = 0;
         press_up();
         e = exp_q.pop_front();
         check("seq_sel", Selector, e);
`ifdef SEL_WRAP_EN
         exp_chg = 1;
`else
         exp_chg = (p < 7) ? 1 : 0;
`endif
         check("seq_chg", chg_seen, exp_chg);
         if (p == 6) begin
            check("seq_max7", sel_at_max, 1);
            check("seq_min7", sel_at_min, 0);
         end
      end
`ifdef SEL_WRAP_EN
      check("seq_max8", sel_at_max, 0);
      check("seq_min8", sel_at_min, 1);
`else
      check("seq_max8", sel_at_max, 1);
      check("seq_min8", sel_at_min, 0);
`endif

      // simultaneous up and down at 3: no change
      do_reset();
      press_up();
      press_up();
      press_up();
      check("sim_pre", Selector, 3);
      chg_seen = 0;
      btn_up   = 1'b1;
      btn_down = 1'b1;
      tick(20);
      btn_up   = 1'b0;
      btn_down = 1'b0;
      tick(12);
      check("sim_sel", Selector, 3);
      check("sim_chg", chg_seen, 0);

      // reset mid-debounce with down held: back to 0, then saturate
      btn_down = 1'b1;
      tick(3);
      reset = 1'b1;
      tick(1);
      check("mrd_sel", Selector, 0);
      check("mrd_min", sel_at_min, 1);
      check("mrd_chg", sel_change, 0);
      reset    = 1'b0;
      chg_seen = 0;
      tick(20);
      check("mrd_sat_sel", Selector, 0);
      check("mrd_sat_chg", chg_seen, 0);
      btn_down = 1'b0;
      tick(12);

      // reset mid-debounce with up held: requalified, one step at R+7
      btn_up = 1'b1;
      tick(3);
      reset = 1'b1;
      tick(1);
      reset    = 1'b0;
      chg_seen = 0;
      tick(7);
      check("mru_early_sel", Selector, 0);
      tick(1);
      check("mru_sel", Selector, 1);
      check("mru_chg", sel_change, 1);
      tick(30);
      btn_up = 1'b0;
      tick(12);
      check("mru_total", chg_seen, 1);

      // down step to 0 then down at 0
      chg_seen = 0;
      press_dn();
      check("dn_sel", Selector, 0);
      check("dn_chg", chg_seen, 1);
      check("dn_min", sel_at_min, 1);
      chg_seen = 0;
      press_dn();
`ifdef SEL_WRAP_EN
      check("dn0_sel", Selector, 7);
      check("dn0_chg", chg_seen, 1);
`else
      check("dn0_sel", Selector, 0);
      check("dn0_chg", chg_seen, 0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
